div_scheduler: RTL and testbench
================================

# div_scheduler

Round-robin scheduler that shares one `unsigned_divider` instance between NREQ requesters. It arbitrates among pending requests and registers the granted operands. It then issues a single-cycle `start_div` to the divider, waits a fixed DIV_LAT cycles, captures quotient, remainder and error, and returns them to the granted requester over a valid/ready response channel. It sits between the symbol-processing clients of the communication datapath and the shared divider.

## Interface
- N, 8, operand/result width; matches divider N.
- NREQ, 4, number of requesters (2..8).
- DIV_LAT, 2, cycles from `div_start` cycle to valid divider outputs (≥1).
- ID_W, $clog2(NREQ), requester index width (derived).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit set.
- req_dividend  in  NREQ*N  packed dividends; slice i belongs to requester i.
- req_divisor  in  NREQ*N  packed divisors.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  ID_W  requester index of the response.
- rsp_quot  out  N  quotient.
- rsp_rem  out  N  remainder.
- rsp_error  out  1  divide-by-zero flag.
- div_in1, div_in2  out  N each  to divider in1/in2; driven from operand registers.
- div_start  out  1  to divider start_div.
- div_quot, div_rem  in  N each  from divider div_out/remainder.
- div_err  in  1  from divider error.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is combinational from `req_valid` and round-robin pointer `rr`. The lowest index ≥ rr with valid wins, wrapping modulo NREQ. `req_ready[g]`=1 only in IDLE. On handshake, capture the operands and g, then go to ISSUE.
- ISSUE: `div_start`=1 for exactly one cycle. Load the wait counter with DIV_LAT and go to WAIT.
- WAIT: counter decrements each cycle. When counter==1, capture `div_quot`, `div_rem`, `div_err` into the response registers and go to RESP.
- RESP: `rsp_valid`=1. `rsp_id` and the data are held stable until `rsp_ready`=1. On the handshake, `rr`←(g+1) mod NREQ and go to IDLE.
- `div_in1`/`div_in2` hold the captured operands from the ISSUE cycle through the end of RESP.
- No new request is accepted outside IDLE, so there is one transaction in flight.
- Requester-side `req_valid` drop before grant is legal; no state is kept for ungranted requesters.
- Reset (any state): abort the current transaction with no response and no `div_start`, then return to IDLE.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0
  - `rsp_quot`/`rsp_rem`=0, `rsp_error`=0
  - `div_start`=0, `div_in1`/`div_in2`=0
  - `rr`=0, state IDLE
- Cycle 0 is the request handshake. `div_start` is asserted in cycle 1. Results are sampled at the end of cycle 1+DIV_LAT. `rsp_valid` rises in cycle 2+DIV_LAT (cycle 4 at the default).
- `rsp_valid` and `rsp_ready` both high in a cycle completes the response. IDLE is in the next cycle, so the earliest next grant is one cycle after the response handshake.
- Simultaneous requests: one grant per transaction in round-robin order. Each requester waits at most NREQ-1 transactions.
- `rsp_ready` held high on entry to RESP: `rsp_valid` is high for exactly one cycle.

## Configuration
- `DIV_SCHED_ZERO_BYPASS_EN` defined:
  - A granted request with divisor==0 skips ISSUE and WAIT and goes IDLE→RESP.
  - `rsp_error`=1, `rsp_quot`=0, `rsp_rem`=0, `rsp_valid` in cycle 1.
  - `div_start` is never asserted for the request.
- Not defined:
  - Zero divisors follow the normal path.
  - `rsp_error`, `rsp_quot` and `rsp_rem` are copied from the divider outputs.

## Test plan
- Req0 5/3 with `rsp_ready`=1 → `div_start` pulse in cycle 1; `rsp_valid` in cycle 4 with id=0, quot=1, rem=2, err=0.
- All four requesters valid at once (12/5, 15/14, 15/11, 15/1) → responses in id order 0,1,2,3 with (2,2), (1,1), (1,4), (15,0). A fresh req0+req3 afterwards → req0 granted first (rr wrapped to 0).
- Req1 11/0 → err=1, quot=0, rem=0, id=1. With bypass: `rsp_valid` in cycle 1 and no `div_start`. Without bypass: `rsp_valid` in cycle 4.
- Req2 15/15 with `rsp_ready` held low 5 cycles, req0 pending → rsp fields stable (quot=1, rem=0), `req_ready`=0 throughout. Req0 is granted the cycle after the response handshake.
- `rst_n` pulsed low during WAIT → all outputs 0 immediately; no `rsp_valid` for the aborted request. A subsequent 0/11 request → quot=0, rem=0, err=0.

Source files
------------

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin front end that shares one unsigned divider among NREQ requesters.
// Optional feature macro DIV_SCHED_ZERO_BYPASS_EN answers zero-divisor requests without the divider.
module div_scheduler #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 2,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [N-1:0]      rsp_quot,
  output logic [N-1:0]      rsp_rem,
  output logic              rsp_error,
  output logic [N-1:0]      div_in1,
  output logic [N-1:0]      div_in2,
  output logic              div_start,
  input  logic [N-1:0]      div_quot,
  input  logic [N-1:0]      div_rem,
  input  logic              div_err
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr, cur_id, gnt_id, any_id, hi_id;
  logic              any_hit, hi_hit, gnt_any, bypass;
  logic [N-1:0]      gnt_dividend, gnt_divisor;
  logic [N-1:0]      op_a, op_b, quot_q, rem_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  // Lowest pending index at or above rr wins; otherwise wrap to the lowest pending index overall.
  always_comb begin
    any_id  = '0;
    hi_id   = '0;
    any_hit = 1'b0;
    hi_hit  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_id  = ID_W'(i);
        any_hit = 1'b1;
        if (ID_W'(i) >= rr) begin
          hi_id  = ID_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    gnt_any = any_hit;
    gnt_id  = hi_hit ? hi_id : any_id;
  end

  assign gnt_dividend = req_dividend[gnt_id*N +: N];
  assign gnt_divisor  = req_divisor[gnt_id*N +: N];

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign bypass = (gnt_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = bypass ? RESP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset also masks the grant so a held-low rst_n never advertises acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr     <= '0;
      cur_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_id <= gnt_id;
            op_a   <= gnt_dividend;
            op_b   <= gnt_divisor;
            if (bypass) begin
              quot_q <= '0;
              rem_q  <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        ISSUE: cnt <= CNT_W'(DIV_LAT);
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            quot_q <= div_quot;
            rem_q  <= div_rem;
            err_q  <= div_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rr <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any && rst_n) req_ready[gnt_id] = 1'b1;
  end

  assign div_start = (state == ISSUE);
  assign div_in1   = op_a;
  assign div_in2   = op_b;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = cur_id;
  assign rsp_quot  = quot_q;
  assign rsp_rem   = rem_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: directed and randomized checks of div_scheduler against a behavioural
// round-robin/divide reference model, with a latency-accurate divider model in the bench.
module tb_div_scheduler;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int DIV_LAT = 2;
  localparam int ID_W    = $clog2(NREQ);
`ifdef DIV_SCHED_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_dividend, req_divisor;
  logic              rsp_valid, rsp_ready, rsp_error, div_start, div_err;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_quot, rsp_rem, div_in1, div_in2, div_quot, div_rem;

  logic [N-1:0]      dvd [NREQ];
  logic [N-1:0]      dvs [NREQ];
  logic [NREQ-1:0]   vld;
  int                total = 0;
  int                bad = 0;
  int                rr_m = 0;

  always #5 clk = ~clk;

  assign req_valid = vld;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_dividend[g*N +: N] = dvd[g];
    assign req_divisor[g*N +: N]  = dvs[g];
  end

  div_scheduler #(.N(N), .NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_error(rsp_error),
    .div_in1(div_in1), .div_in2(div_in2), .div_start(div_start),
    .div_quot(div_quot), .div_rem(div_rem), .div_err(div_err)
  );

  // Divider model: results are valid only during cycle start+DIV_LAT, noise otherwise.
  int           cd = -1;
  logic [N-1:0] ma, mb;
  always @(negedge clk) begin
    if (div_start) begin
      cd = DIV_LAT;
      ma = div_in1;
      mb = div_in2;
    end else if (cd >= 0) begin
      cd = cd - 1;
    end
    if (cd == 0) begin
      div_quot = (mb == 0) ? '0 : ma / mb;
      div_rem  = (mb == 0) ? '0 : ma % mb;
      div_err  = (mb == 0);
    end else begin
      div_quot = N'($urandom);
      div_rem  = N'($urandom);
      div_err  = 1'($urandom);
    end
  end

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_req_ready"}, 32'(req_ready), 0);
    check_output({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_output({tag, "_rsp_fields"}, {rsp_id, rsp_quot, rsp_rem, rsp_error}, 0);
    check_output({tag, "_div_start"}, 32'(div_start), 0);
    check_output({tag, "_div_in"}, {div_in1, div_in2}, 0);
  endtask

  // One full transaction: grant, issue, wait, response with optional back-pressure.
  task automatic serve_one(input int ready_delay, output int wait_cyc);
    int              id, cyc, start_cnt, start_cyc, busy_rdy, lat;
    logic [N-1:0]    a, b, eq, er;
    logic            ee;
    logic [NREQ-1:0] exp_oh;
    #1;
    id = pick(vld, rr_m);
    wait_cyc = 0;
    rsp_ready = (ready_delay == 0);
    while (req_ready == '0 && wait_cyc < 10) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    exp_oh = '0;
    exp_oh[id] = 1'b1;
    check_output("grant", 32'(req_ready), 32'(exp_oh));
    a = dvd[id];
    b = dvs[id];
    if (b == 0) begin
      eq = '0; er = '0; ee = 1'b1;
    end else begin
      eq = a / b; er = a % b; ee = 1'b0;
    end
    lat = (BYP && b == 0) ? 1 : 2 + DIV_LAT;
    cyc = 0; start_cnt = 0; start_cyc = -1; busy_rdy = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 1) vld[id] = 1'b0;
      if (div_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (req_ready != '0) busy_rdy++;
    end while (!rsp_valid && cyc < 20);
    check_output("rsp_latency", cyc, lat);
    check_output("div_start_count", start_cnt, (BYP && b == 0) ? 0 : 1);
    check_output("div_start_cycle", start_cyc, (BYP && b == 0) ? -1 : 1);
    check_output("busy_no_ready", busy_rdy, 0);
    check_output("rsp_id", 32'(rsp_id), id);
    check_output("rsp_quot", 32'(rsp_quot), 32'(eq));
    check_output("rsp_rem", 32'(rsp_rem), 32'(er));
    check_output("rsp_error", 32'(rsp_error), 32'(ee));
    for (int k = 1; k < ready_delay; k++) begin
      @(negedge clk); #1;
      check_output("hold_valid", 32'(rsp_valid), 1);
      check_output("hold_data", {rsp_id, rsp_quot, rsp_rem, rsp_error}, {id[ID_W-1:0], eq, er, ee});
      check_output("hold_no_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_output("rsp_single", 32'(rsp_valid), 0);
    rr_m = (id + 1) % NREQ;
    rsp_ready = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] mask, input int max_delay);
    int w;
    vld = vld | mask;
    while (vld != '0) serve_one($urandom_range(max_delay, 0), w);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, cnt_v, cnt_s;
    logic [NREQ-1:0] mask;
    for (int i = 0; i < NREQ; i++) begin
      dvd[i] = '0;
      dvs[i] = '0;
    end
    rsp_ready = 1'b0;
    vld = '1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] all four requesters at once");
    dvd[0] = 12; dvs[0] = 5;
    dvd[1] = 15; dvs[1] = 14;
    dvd[2] = 15; dvs[2] = 11;
    dvd[3] = 15; dvs[3] = 1;
    vld = 4'hF;
    for (int t = 0; t < 4; t++) begin
      check_output("rr_order", pick(vld, rr_m), t);
      serve_one(0, w);
    end
    dvd[0] = 9; dvs[0] = 2;
    dvd[3] = 7; dvs[3] = 7;
    vld = 4'b1001;
    check_output("rr_wrap", pick(vld, rr_m), 0);
    apply_stimulus(4'b0000, 0);

    $display("[TB] single request 5/3");
    dvd[0] = 5; dvs[0] = 3;
    vld[0] = 1'b1;
    serve_one(0, w);

    $display("[TB] divide by zero 11/0");
    dvd[1] = 11; dvs[1] = 0;
    vld[1] = 1'b1;
    serve_one(0, w);

    $display("[TB] back-pressure with req0 pending");
    dvd[2] = 15; dvs[2] = 15;
    dvd[0] = 100; dvs[0] = 9;
    vld = 4'b0101;
    serve_one(5, w);
    serve_one(0, w);
    check_output("grant_after_hs", w, 0);

    $display("[TB] reset during WAIT");
    dvd[1] = 200; dvs[1] = 7;
    vld = 4'b1010;
    #1;
    check_output("pre_reset_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    cnt_v = 0; cnt_s = 0;
    repeat (8) begin
      @(negedge clk); #1;
      cnt_v += rsp_valid;
      cnt_s += div_start;
    end
    check_output("abort_no_rsp", cnt_v, 0);
    check_output("abort_no_start", cnt_s, 0);
    dvd[2] = 0; dvs[2] = 11;
    vld[2] = 1'b1;
    serve_one(0, w);

    $display("[TB] randomized batches");
    for (int t = 0; t < 40; t++) begin
      mask = NREQ'($urandom_range(15, 1));
      for (int i = 0; i < NREQ; i++) begin
        dvd[i] = N'($urandom);
        dvs[i] = ($urandom_range(7, 0) == 0) ? '0 : N'($urandom_range(255, 1));
      end
      apply_stimulus(mask, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
